flappy_game_ctrl: RTL and testbench

- Parametrised game-state controller for the Flappy Bird VGA game. Sits between the bird physics block, the RNG and the VGA/7-segment drivers.
- Owns the LOST/RESET/PLAY state machine, the scroll-rate accumulator driven by the heart-rate speed code, an N-deep pipe gap queue, collision detection, and saturating current/high scores.
- Successor to the fixed two-pipe, single-rate controller: it adds configurable pipe depth, four defined speed steps, pause edge detection, a single-cycle scroll strobe instead of a derived clock, and unambiguous collision priority.

---
 rtl/flappy_game_ctrl.sv | 160 ++++++++++++++++
 tb/tb_flappy_game_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/flappy_game_ctrl.sv
// Game-state controller: LOST/RESET/PLAY FSM, scroll accumulator, pipe gap queue, collision and scores.
// Latency: all outputs registered; inputs act on the next clk edge, and clr clears every output immediately.
// Backpressure: none; inputs are sampled every cycle and a scroll step that coincides with a loss is dropped.
module flappy_game_ctrl #(
    parameter int NUM_PIPES = 2,
    parameter int PIPE_SPAN = 345,
    parameter int PIPE_X0   = 439,
    parameter int PIPE_W    = 50,
    parameter int BIRD_XL   = 244,
    parameter int BIRD_XR   = 284,
    parameter int BIRD_HALF = 20,
    parameter int SCREEN_H  = 480,
    parameter int GAP_TOP   = 75,
    parameter int GAP_BOT   = 215,
    parameter int GAP_INIT  = 100,
    parameter int SCORE_W   = 4,
    parameter int TICK_W    = 18
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     jump,
    input  logic                     rst_game,
    input  logic                     pause_btn,
    input  logic [1:0]               speed_sel,
    input  logic [7:0]               rand_val,
    input  logic [9:0]               bird_y,
    output logic [1:0]               state,
    output logic                     paused,
    output logic                     scroll_tick,
    output logic [9:0]               pipe_pos,
    output logic [8*NUM_PIPES-1:0]   pipe_gaps,
    output logic [SCORE_W-1:0]       current_score,
    output logic [SCORE_W-1:0]       high_score,
    output logic                     hit
);

    typedef enum logic [1:0] {
        ST_LOST  = 2'd0,
        ST_RESET = 2'd1,
        ST_PLAY  = 2'd2,
        ST_BAD   = 2'd3
    } state_t;

    localparam int AW = TICK_W + 1;

    // Geometry constants in the 12-bit signed domain used by the collision test
    localparam logic signed [11:0] C_X0  = 12'(PIPE_X0);
    localparam logic signed [11:0] C_PW  = 12'(PIPE_W);
    localparam logic signed [11:0] C_BXL = 12'(BIRD_XL);
    localparam logic signed [11:0] C_BXR = 12'(BIRD_XR);
    localparam logic signed [11:0] C_BH  = 12'(BIRD_HALF);
    localparam logic signed [11:0] C_SH  = 12'(SCREEN_H);
    localparam logic signed [11:0] C_GT  = 12'(GAP_TOP);
    localparam logic signed [11:0] C_GB  = 12'(GAP_BOT);

    localparam logic [8*NUM_PIPES-1:0] GAPS_INIT = {NUM_PIPES{8'(GAP_INIT)}};
    localparam logic [SCORE_W-1:0]     SCORE_MAX = {SCORE_W{1'b1}};

    state_t              st;
    logic [TICK_W-1:0]   acc;
    logic [AW-1:0]       acc_sum;
    logic                pause_q;
    logic                pause_rise;
    logic signed [11:0]  px;
    logic signed [11:0]  by;
    logic signed [11:0]  gap0;
    logic                overlap;
    logic                vert_hit;
    logic                loss;

    assign state = st;

    // Step size is speed_sel+1; the carry out of the accumulator is the scroll strobe
    assign acc_sum    = AW'(acc) + AW'(speed_sel) + AW'(1);
    assign pause_rise = pause_btn & ~pause_q;

    // Bird-vs-pipe geometry; negative screen y is possible for very high birds
    assign px       = C_X0 - $signed({2'b00, pipe_pos});
    assign by       = C_SH - $signed({2'b00, bird_y});
    assign gap0     = $signed({4'b0000, pipe_gaps[7:0]});
    assign overlap  = (C_BXR > px) && (C_BXL < px + C_PW);
    assign vert_hit = (by - C_BH < gap0 + C_GT) || (by + C_BH > gap0 + C_GB);
    // Floor contact loses regardless of where the pipe is
    assign loss     = (st == ST_PLAY) && !paused && ((overlap && vert_hit) || (bird_y == 10'd0));

    // Free-running scroll accumulator and pause edge register, active in every state
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            acc         <= '0;
            scroll_tick <= 1'b0;
            pause_q     <= 1'b0;
        end else begin
            acc         <= acc_sum[TICK_W-1:0];
            scroll_tick <= acc_sum[TICK_W];
            pause_q     <= pause_btn;
        end
    end

    // Game FSM with pipe scrolling, gap queue, scores and the one-cycle hit flag
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            st            <= ST_RESET;
            paused        <= 1'b0;
            pipe_pos      <= '0;
            pipe_gaps     <= GAPS_INIT;
            current_score <= '0;
            high_score    <= '0;
            hit           <= 1'b0;
        end else begin
            hit <= 1'b0;
            if (current_score > high_score) begin
                high_score <= current_score;
            end
            case (st)
                ST_RESET: begin
                    pipe_pos      <= '0;
                    current_score <= '0;
                    pipe_gaps     <= GAPS_INIT;
                    paused        <= 1'b0;
                    if (jump) begin
                        st <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (loss) begin
                        // Loss wins over any scroll or pause toggle in the same cycle
                        st     <= ST_LOST;
                        hit    <= 1'b1;
                        paused <= 1'b0;
                    end else begin
                        if (pause_rise) begin
                            paused <= ~paused;
                        end
                        if (scroll_tick && !paused) begin
                            if (pipe_pos < 10'(PIPE_SPAN)) begin
                                pipe_pos <= pipe_pos + 10'd1;
                            end else begin
                                pipe_pos  <= '0;
                                pipe_gaps <= {rand_val, pipe_gaps[8*NUM_PIPES-1:8]};
                                if (current_score != SCORE_MAX) begin
                                    current_score <= current_score + SCORE_W'(1);
                                end
                            end
                        end
                    end
                end
                ST_LOST: begin
                    if (rst_game) begin
                        st <= ST_RESET;
                    end
                end
                default: begin
                    st     <= ST_RESET;
                    paused <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flappy_game_ctrl.sv
module tb_flappy_game_ctrl;

    localparam int NP   = 3;
    localparam int SPAN = 345;
    localparam int X0   = 439;
    localparam int PW   = 50;
    localparam int BXL  = 244;
    localparam int BXR  = 284;
    localparam int BH   = 20;
    localparam int SH   = 480;
    localparam int GT   = 75;
    localparam int GB   = 215;
    localparam int GI   = 100;
    localparam int SW   = 2;
    localparam int TW   = 4;

    logic            clk       = 1'b0;
    logic            clr       = 1'b0;
    logic            jump      = 1'b0;
    logic            rst_game  = 1'b0;
    logic            pause_btn = 1'b0;
    logic [1:0]      speed_sel = 2'd0;
    logic [7:0]      rand_val  = 8'd0;
    logic [9:0]      bird_y    = 10'd200;
    logic [1:0]      state;
    logic            paused;
    logic            scroll_tick;
    logic [9:0]      pipe_pos;
    logic [8*NP-1:0] pipe_gaps;
    logic [SW-1:0]   current_score;
    logic [SW-1:0]   high_score;
    logic            hit;

    flappy_game_ctrl #(
        .NUM_PIPES(NP), .PIPE_SPAN(SPAN), .PIPE_X0(X0), .PIPE_W(PW),
        .BIRD_XL(BXL), .BIRD_XR(BXR), .BIRD_HALF(BH), .SCREEN_H(SH),
        .GAP_TOP(GT), .GAP_BOT(GB), .GAP_INIT(GI), .SCORE_W(SW), .TICK_W(TW)
    ) dut (
        .clk(clk), .clr(clr), .jump(jump), .rst_game(rst_game),
        .pause_btn(pause_btn), .speed_sel(speed_sel), .rand_val(rand_val),
        .bird_y(bird_y), .state(state), .paused(paused),
        .scroll_tick(scroll_tick), .pipe_pos(pipe_pos), .pipe_gaps(pipe_gaps),
        .current_score(current_score), .high_score(high_score), .hit(hit)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_state, m_paused, m_tick, m_pos, m_score, m_high, m_hit, m_acc, m_pq;
    int m_gap[NP];

    always @(posedge clk or posedge clr) begin
        int n_state, n_paused, n_tick, n_pos, n_score, n_high, n_hit, n_acc, sum, px, by;
        int n_gap[NP];
        bit rise, lose;
        if (clr) begin
            m_state = 1; m_paused = 0; m_tick = 0; m_pos = 0; m_score = 0;
            m_high = 0; m_hit = 0; m_acc = 0; m_pq = 0;
            for (int i = 0; i < NP; i++) m_gap[i] = GI;
        end else begin
            n_state = m_state; n_paused = m_paused; n_pos = m_pos; n_score = m_score;
            n_gap = m_gap;
            n_hit = 0;
            n_high = (m_score > m_high) ? m_score : m_high;
            sum = m_acc + int'(speed_sel) + 1;
            n_tick = (sum >= (1 << TW)) ? 1 : 0;
            n_acc = sum % (1 << TW);
            rise = pause_btn && (m_pq == 0);
            if (m_state == 1) begin
                n_pos = 0; n_score = 0; n_paused = 0;
                for (int i = 0; i < NP; i++) n_gap[i] = GI;
                if (jump) n_state = 2;
            end else if (m_state == 2) begin
                px = X0 - m_pos;
                by = SH - int'(bird_y);
                lose = (m_paused == 0) &&
                       (((BXR > px) && (BXL < px + PW) &&
                         ((by - BH < m_gap[0] + GT) || (by + BH > m_gap[0] + GB))) ||
                        (bird_y == 0));
                if (lose) begin
                    n_state = 0; n_hit = 1; n_paused = 0;
                end else begin
                    if (rise) n_paused = (m_paused == 0) ? 1 : 0;
                    if (m_tick == 1 && m_paused == 0) begin
                        if (m_pos < SPAN) n_pos = m_pos + 1;
                        else begin
                            n_pos = 0;
                            for (int i = 0; i < NP - 1; i++) n_gap[i] = m_gap[i + 1];
                            n_gap[NP - 1] = int'(rand_val);
                            if (m_score < (1 << SW) - 1) n_score = m_score + 1;
                        end
                    end
                end
            end else if (m_state == 0) begin
                if (rst_game) n_state = 1;
            end
            m_state = n_state; m_paused = n_paused; m_tick = n_tick; m_pos = n_pos;
            m_score = n_score; m_high = n_high; m_hit = n_hit; m_acc = n_acc;
            m_pq = pause_btn ? 1 : 0;
            m_gap = n_gap;
        end
    end

    // Compare every output against the model on each falling edge
    always @(negedge clk) begin
        logic [8*NP-1:0] eg;
        if (chk_en) begin
            for (int i = 0; i < NP; i++) eg[8*i +: 8] = 8'(m_gap[i]);
            chk("m_state", 64'(state), 64'(m_state));
            chk("m_paused", 64'(paused), 64'(m_paused));
            chk("m_tick", 64'(scroll_tick), 64'(m_tick));
            chk("m_pos", 64'(pipe_pos), 64'(m_pos));
            chk("m_gaps", 64'(pipe_gaps), 64'(eg));
            chk("m_score", 64'(current_score), 64'(m_score));
            chk("m_high", 64'(high_score), 64'(m_high));
            chk("m_hit", 64'(hit), 64'(m_hit));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_pos(input int p, input string name);
        int k = 0;
        while (pipe_pos != 10'(p) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk(name, 64'(pipe_pos), 64'(p));
    endtask

    task automatic pulse_jump();
        jump = 1'b1; @(negedge clk); jump = 1'b0;
    endtask

    task automatic pulse_rst_game();
        rst_game = 1'b1; @(negedge clk); rst_game = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, 64'(state), 64'd1);
        chk({tag, "_pos"}, 64'(pipe_pos), 64'd0);
        chk({tag, "_gaps"}, 64'(pipe_gaps), 64'h646464);
        chk({tag, "_score"}, 64'(current_score), 64'd0);
        chk({tag, "_high"}, 64'(high_score), 64'd0);
        chk({tag, "_hit"}, 64'(hit), 64'd0);
        chk({tag, "_paused"}, 64'(paused), 64'd0);
        chk({tag, "_tick"}, 64'(scroll_tick), 64'd0);
    endtask

    initial begin
        int cnt;
        int p;
        #1 clr = 1'b1;
        chk_en = 1'b1;
        #2 chk_reset_vals("reset");
        @(negedge clk); @(negedge clk);
        clr = 1'b0;
        speed_sel = 2'd3; rand_val = 8'h5A; bird_y = 10'd200;
        repeat (3) @(negedge clk);
        chk("idle_state", 64'(state), 64'd1);
        pulse_jump();
        chk("jump_play", 64'(state), 64'd2);

        // Speed 3 on a 4-bit accumulator: one strobe per 4 cycles
        cnt = 0;
        repeat (40) begin @(negedge clk); cnt += int'(scroll_tick); end
        chk("tick_rate", 64'(cnt), 64'd10);

        // First wrap shifts the gap queue and scores
        wait_pos(SPAN, "reach_span");
        wait_pos(0, "wrap");
        chk("wrap_gaps", 64'(pipe_gaps), 64'h5A6464);
        chk("wrap_score", 64'(current_score), 64'd1);
        chk("wrap_high_lag", 64'(high_score), 64'd0);
        @(negedge clk);
        chk("wrap_high", 64'(high_score), 64'd1);

        // Overlap at pipe_pos 170: bird inside gap survives, bird above gap top dies
        wait_pos(170, "reach_170");
        chk("no_hit_200", 64'(state), 64'd2);
        bird_y = 10'd350;
        @(negedge clk);
        chk("pipe_loss_state", 64'(state), 64'd0);
        chk("pipe_loss_hit", 64'(hit), 64'd1);
        chk("pipe_loss_pos", 64'(pipe_pos), 64'd170);
        @(negedge clk);
        chk("hit_one_cycle", 64'(hit), 64'd0);
        bird_y = 10'd200;
        repeat (8) @(negedge clk);
        chk("lost_frozen_pos", 64'(pipe_pos), 64'd170);
        pulse_jump();
        chk("lost_ignores_jump", 64'(state), 64'd0);
        pulse_rst_game();
        chk("rst_game_state", 64'(state), 64'd1);
        @(negedge clk);
        chk("rst_game_score", 64'(current_score), 64'd0);
        chk("rst_game_high", 64'(high_score), 64'd1);
        chk("rst_game_gaps", 64'(pipe_gaps), 64'h646464);

        // Floor loss with the pipe far from the bird
        pulse_jump();
        repeat (3) @(negedge clk);
        bird_y = 10'd0;
        @(negedge clk);
        chk("floor_state", 64'(state), 64'd0);
        chk("floor_hit", 64'(hit), 64'd1);
        bird_y = 10'd200;
        pulse_rst_game();

        // Held pause button toggles once; paused game neither scrolls nor loses
        pulse_jump();
        repeat (5) @(negedge clk);
        pause_btn = 1'b1;
        repeat (10) @(negedge clk);
        chk("pause_held", 64'(paused), 64'd1);
        p = int'(pipe_pos);
        bird_y = 10'd0;
        repeat (20) @(negedge clk);
        chk("pause_pos", 64'(pipe_pos), 64'(p));
        chk("pause_no_loss", 64'(state), 64'd2);
        bird_y = 10'd200;
        pause_btn = 1'b0;
        @(negedge clk);
        pause_btn = 1'b1;
        @(negedge clk);
        pause_btn = 1'b0;
        chk("resume", 64'(paused), 64'd0);
        repeat (12) @(negedge clk);
        chk("resume_moves", 64'(pipe_pos > 10'(p)), 64'd1);

        // Pause edge together with a loss: loss wins and pause stays clear
        pause_btn = 1'b1; bird_y = 10'd0;
        @(negedge clk);
        chk("pause_loss_state", 64'(state), 64'd0);
        chk("pause_loss_paused", 64'(paused), 64'd0);
        pause_btn = 1'b0; bird_y = 10'd200;
        pulse_rst_game();

        // Four wraps on a 2-bit score saturate at 3
        rand_val = 8'h80;
        pulse_jump();
        for (int w = 0; w < 4; w++) begin
            wait_pos(SPAN, "sat_span");
            wait_pos(0, "sat_wrap");
        end
        chk("sat_score", 64'(current_score), 64'd3);
        @(negedge clk);
        chk("sat_high", 64'(high_score), 64'd3);

        // Asynchronous clear in the middle of play
        repeat (20) @(negedge clk);
        @(posedge clk);
        #2 clr = 1'b1;
        #1 chk_reset_vals("async_clr");
        @(negedge clk);
        clr = 1'b0;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
